// File: rtl/hilbert_transform_stream.sv
// Streaming Hilbert transformer: dataOutIm is a LENGTH-tap FIR of dataIn, dataOutRe the input
// delayed by (LENGTH-1)/2 accepted samples. Define HT_ROUND_EN to round/saturate dataOutIm.
module hilbert_transform_stream #(
  parameter int LENGTH     = 27,
  parameter int DATA_WIDTH = 18,
  parameter int OUT_WIDTH  = 3*DATA_WIDTH,
  parameter int FRAC_BITS  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         stopDataInFlag,
  input  logic signed [DATA_WIDTH-1:0] coeffIn,
  input  logic                         coeffInValid,
  output logic                         coeffSetFlag,
  input  logic                         dataInValid,
  input  logic signed [DATA_WIDTH-1:0] dataIn,
  output logic                         dataOutValid,
  output logic signed [OUT_WIDTH-1:0]  dataOutRe,
  output logic signed [OUT_WIDTH-1:0]  dataOutIm
);
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(LENGTH);
  localparam int D     = (LENGTH-1)/2;
  localparam int CW    = $clog2(LENGTH);
  localparam int FW    = $clog2(D+1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_COEFF = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;
  state_t state, stateNext;

  logic signed [DATA_WIDTH-1:0]   coeffReg [LENGTH];
  logic signed [DATA_WIDTH-1:0]   taps     [LENGTH];
  logic signed [DATA_WIDTH-1:0]   tapsNext [LENGTH];
  logic        [CW-1:0]           loadCnt;
  logic        [FW-1:0]           flushCnt;
  logic                           shiftEn, clearLines, writeCoeff, coeffDone, flushDone;
  logic signed [DATA_WIDTH-1:0]   shiftIn;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc;
  logic signed [OUT_WIDTH-1:0]    imValue;

  assign coeffDone = writeCoeff && (loadCnt == CW'(LENGTH-1));
  assign flushDone = (flushCnt == FW'(D-1));

  // Next-state and datapath control
  always_comb begin
    stateNext  = state;
    shiftEn    = 1'b0;
    shiftIn    = dataIn;
    clearLines = 1'b0;
    writeCoeff = 1'b0;
    case (state)
      IDLE: begin
        clearLines = 1'b1;
        if (enable) begin
          if (coeffSetFlag) stateNext = RUN;
          else              stateNext = LOAD_COEFF;
        end else begin
          stateNext = IDLE;
        end
      end
      LOAD_COEFF: begin
        writeCoeff = coeffInValid;
        if (coeffDone) stateNext = RUN;
        else           stateNext = LOAD_COEFF;
      end
      RUN: begin
        shiftEn = dataInValid;
        if (stopDataInFlag) stateNext = FLUSH;
        else                stateNext = RUN;
      end
      FLUSH: begin
        shiftEn = 1'b1;
        shiftIn = {DATA_WIDTH{1'b0}};
        if (flushDone) stateNext = IDLE;
        else           stateNext = FLUSH;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Shifted tap line and full-precision FIR sum (includes the sample being accepted)
  always_comb begin
    tapsNext[0] = shiftIn;
    for (int k = 1; k < LENGTH; k++) begin
      tapsNext[k] = taps[k-1];
    end
    acc  = {ACC_W{1'b0}};
    prod = {(2*DATA_WIDTH){1'b0}};
    for (int k = 0; k < LENGTH; k++) begin
      prod = coeffReg[k] * tapsNext[k];
      acc  = acc + ACC_W'(prod);
    end
  end

`ifdef HT_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS-1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W:0]        rounded, shifted;
  logic signed [DATA_WIDTH-1:0] satIm;

  // Round half up to the integer grid, then clamp to the sample range
  always_comb begin
    rounded = (ACC_W+1)'(acc) + ROUND_HALF;
    shifted = rounded >>> FRAC_BITS;
    if (shifted > SAT_MAX)      satIm = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) satIm = SAT_MIN[DATA_WIDTH-1:0];
    else                        satIm = shifted[DATA_WIDTH-1:0];
    imValue = OUT_WIDTH'(satIm);
  end
`else
  logic unusedFracBits;
  assign unusedFracBits = |FRAC_BITS;

  // Full-precision imaginary part
  always_comb begin
    imValue = OUT_WIDTH'(acc);
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Coefficient store, counters, tap line and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      coeffSetFlag <= 1'b0;
      loadCnt      <= {CW{1'b0}};
      flushCnt     <= {FW{1'b0}};
      dataOutValid <= 1'b0;
      dataOutRe    <= {OUT_WIDTH{1'b0}};
      dataOutIm    <= {OUT_WIDTH{1'b0}};
      for (int k = 0; k < LENGTH; k++) begin
        coeffReg[k] <= {DATA_WIDTH{1'b0}};
        taps[k]     <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < LENGTH; k++) begin
        if (writeCoeff && (loadCnt == CW'(k))) coeffReg[k] <= coeffIn;
      end
      if (clearLines)      loadCnt <= {CW{1'b0}};
      else if (writeCoeff) loadCnt <= loadCnt + CW'(1'b1);
      if (coeffDone) coeffSetFlag <= 1'b1;
      if ((state == FLUSH) && !flushDone) flushCnt <= flushCnt + FW'(1'b1);
      else                                flushCnt <= {FW{1'b0}};
      dataOutValid <= shiftEn;
      if (clearLines) begin
        dataOutRe <= {OUT_WIDTH{1'b0}};
        dataOutIm <= {OUT_WIDTH{1'b0}};
        for (int k = 0; k < LENGTH; k++) taps[k] <= {DATA_WIDTH{1'b0}};
      end else if (shiftEn) begin
        // The tap line doubles as the Re delay line: tap D holds the sample D accepts back
        dataOutRe <= OUT_WIDTH'(tapsNext[D]);
        dataOutIm <= imValue;
        for (int k = 0; k < LENGTH; k++) taps[k] <= tapsNext[k];
      end
    end
  end
endmodule
